// File: rtl/prim_ram_2p_sync.sv
// prim_ram_2p_sync
// ----------------
// Single-clock true dual-port RAM. Ports A and B share one storage array,
// and either port can read or write it on any cycle. The block never stalls.
//
// Read behaviour
//   - Read-first: a read returns the word as it was before any write at the
//     same edge. This holds for a write on either port.
//   - A read completes one cycle after the request. With OutputReg=1 it
//     completes two cycles after the request. Reads are fully pipelined.
//   - rdata holds its value until the next read on that port completes.
//   - An out-of-range read (addr >= Depth) still completes. It returns 0.
//
// Write behaviour
//   - Writes are byte-lane masked.
//   - An out-of-range write is discarded.
//   - When both ports write the same word, lanes enabled by both ports take
//     port A data.
//
// collision_o
//   Pulses for one cycle, one cycle after either of these at one edge, for
//   the same in-range address:
//   - both ports write with overlapping lane masks;
//   - one port writes (non-zero mask) while the other port reads.
//
// Reset (rst_i, synchronous, active high)
//   - Clears all valid, data and collision flops.
//   - Drops reads in flight.
//   - Ignores requests presented during reset.
//   - Leaves the array contents untouched.
//
// Ports
//   clk_i, rst_i                     clock, synchronous active-high reset
//   {a,b}_req_i, {a,b}_write_i       access request, 1 = write / 0 = read
//   {a,b}_addr_i [Aw]                word address
//   {a,b}_wdata_i [Width]            write data
//   {a,b}_wmask_i [Mw]               lane enables, lane i = bits [i*DBPM +: DBPM]
//   {a,b}_rdata_o [Width]            read data
//   {a,b}_rvalid_o                   one-cycle strobe: rdata carries a new result
//   collision_o                      one-cycle same-address conflict pulse
module prim_ram_2p_sync #(
  parameter int Width           = 32,
  parameter int Depth           = 128,
  parameter int DataBitsPerMask = 8,
  parameter bit OutputReg       = 1'b0,
  parameter     MemInitFile     = "",
  localparam int Aw = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int Mw = Width / DataBitsPerMask
) (
  input  logic             clk_i,
  input  logic             rst_i,

  input  logic             a_req_i,
  input  logic             a_write_i,
  input  logic [Aw-1:0]    a_addr_i,
  input  logic [Width-1:0] a_wdata_i,
  input  logic [Mw-1:0]    a_wmask_i,
  output logic [Width-1:0] a_rdata_o,
  output logic             a_rvalid_o,

  input  logic             b_req_i,
  input  logic             b_write_i,
  input  logic [Aw-1:0]    b_addr_i,
  input  logic [Width-1:0] b_wdata_i,
  input  logic [Mw-1:0]    b_wmask_i,
  output logic [Width-1:0] b_rdata_o,
  output logic             b_rvalid_o,

  output logic             collision_o
);

  // Depth held one bit wider than an address, so addresses of any value
  // compare cleanly against it even when Depth is a power of two.
  localparam logic [Aw:0] DepthW = (Aw+1)'(Depth);

  if (Width % DataBitsPerMask != 0) begin : g_bad_mask_width
    $error("prim_ram_2p_sync: Width must be a multiple of DataBitsPerMask");
  end

  logic [Width-1:0] mem [Depth];

  // ---------------------------------------------------------------------
  // Request decode. Requests presented during reset are ignored entirely.
  // ---------------------------------------------------------------------
  logic             a_in_range, b_in_range;
  logic             a_rd, a_wr, b_rd, b_wr;
  logic             same_addr;
  logic             collision_d;
  logic [Width-1:0] a_rdata_raw, b_rdata_raw;

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    a_in_range  = ({1'b0, a_addr_i} < DepthW);
    b_in_range  = ({1'b0, b_addr_i} < DepthW);
    a_rd        = !rst_i && a_req_i && !a_write_i;
    a_wr        = !rst_i && a_req_i &&  a_write_i;
    b_rd        = !rst_i && b_req_i && !b_write_i;
    b_wr        = !rst_i && b_req_i &&  b_write_i;
    same_addr   = (a_addr_i == b_addr_i) && a_in_range;

    collision_d = same_addr &&
                  ((a_wr && b_wr && |(a_wmask_i & b_wmask_i)) ||
                   (a_wr && |a_wmask_i && b_rd) ||
                   (b_wr && |b_wmask_i && a_rd));

    // Sampled before this edge's writes land, which gives read-first
    // behaviour on both ports.
    a_rdata_raw = '0;
    b_rdata_raw = '0;
    if (a_in_range) a_rdata_raw = mem[a_addr_i];
    if (b_in_range) b_rdata_raw = mem[b_addr_i];
  end

  // ---------------------------------------------------------------------
  // Storage. Port B lanes are written first and port A second, so port A
  // wins on any lane that both ports enable for the same word.
  // ---------------------------------------------------------------------
  // NOTE: the array has no reset; clearing it would turn the RAM into flops.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < Mw; i++) begin
      if (b_wr && b_in_range && b_wmask_i[i]) begin
        mem[b_addr_i][i*DataBitsPerMask +: DataBitsPerMask] <=
          b_wdata_i[i*DataBitsPerMask +: DataBitsPerMask];
      end
      if (a_wr && a_in_range && a_wmask_i[i]) begin
        mem[a_addr_i][i*DataBitsPerMask +: DataBitsPerMask] <=
          a_wdata_i[i*DataBitsPerMask +: DataBitsPerMask];
      end
    end
  end

  // ---------------------------------------------------------------------
  // First read stage and collision flag
  // ---------------------------------------------------------------------
  logic             a_rvalid_q, b_rvalid_q;
  logic [Width-1:0] a_rdata_q,  b_rdata_q;
  logic             collision_q;

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      collision_q <= 1'b0;
    end else begin
      a_rvalid_q  <= a_rd;
      b_rvalid_q  <= b_rd;
      if (a_rd) a_rdata_q <= a_rdata_raw;
      if (b_rd) b_rdata_q <= b_rdata_raw;
      collision_q <= collision_d;
    end
  end

  assign collision_o = collision_q;

  // ---------------------------------------------------------------------
  // Optional output register
  // ---------------------------------------------------------------------
  if (OutputReg) begin : g_out_reg
    logic             a_rvalid_q2, b_rvalid_q2;
    logic [Width-1:0] a_rdata_q2,  b_rdata_q2;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        a_rvalid_q2 <= 1'b0;
        b_rvalid_q2 <= 1'b0;
        a_rdata_q2  <= '0;
        b_rdata_q2  <= '0;
      end else begin
        a_rvalid_q2 <= a_rvalid_q;
        b_rvalid_q2 <= b_rvalid_q;
        // Only a completing read moves the data, so rdata holds between reads.
        if (a_rvalid_q) a_rdata_q2 <= a_rdata_q;
        if (b_rvalid_q) b_rdata_q2 <= b_rdata_q;
      end
    end

    assign a_rvalid_o = a_rvalid_q2;
    assign b_rvalid_o = b_rvalid_q2;
    assign a_rdata_o  = a_rdata_q2;
    assign b_rdata_o  = b_rdata_q2;
  end else begin : g_no_out_reg
    assign a_rvalid_o = a_rvalid_q;
    assign b_rvalid_o = b_rvalid_q;
    assign a_rdata_o  = a_rdata_q;
    assign b_rdata_o  = b_rdata_q;
  end

`ifndef SYNTHESIS
  a_ctrl_known: assert property (@(posedge clk_i) disable iff (rst_i)
    !$isunknown({a_req_i, a_write_i, a_addr_i}));
  b_ctrl_known: assert property (@(posedge clk_i) disable iff (rst_i)
    !$isunknown({b_req_i, b_write_i, b_addr_i}));
`endif

endmodule

// File: tb/tb_prim_ram_2p_sync.sv
// Testbench for prim_ram_2p_sync.
//
// Two instances share one stimulus stream:
//   - dut0 has OutputReg=0 (1-cycle read latency);
//   - dut1 has OutputReg=1 (2-cycle read latency).
// Both use Depth=100, so addresses 100..127 are out of range.
//
// After every clock edge, all outputs of both instances are compared
// against a word/lane-level reference model. A directed table and a few
// hand-written sequences also carry their own expected values.
module tb_prim_ram_2p_sync;

  localparam int W     = 32;
  localparam int DEPTH = 100;
  localparam int AW    = 7;
  localparam int MW    = 4;

  typedef struct {
    bit          rst;
    bit          a_req, a_write;
    logic [6:0]  a_addr;
    logic [31:0] a_wdata;
    logic [3:0]  a_mask;
    bit          b_req, b_write;
    logic [6:0]  b_addr;
    logic [31:0] b_wdata;
    logic [3:0]  b_mask;
  } vec_t;

  typedef struct {
    vec_t        in;
    bit          xav;
    logic [31:0] xad;
    bit          xbv;
    logic [31:0] xbd;
    bit          xcol;
  } row_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_write, b_req, b_write;
  logic [AW-1:0] a_addr, b_addr;
  logic [W-1:0]  a_wdata, b_wdata;
  logic [MW-1:0] a_wmask, b_wmask;

  logic [W-1:0]  a_rdata0, b_rdata0, a_rdata1, b_rdata1;
  logic          a_rvalid0, b_rvalid0, a_rvalid1, b_rvalid1, col0, col1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  prim_ram_2p_sync #(.Width(W), .Depth(DEPTH), .DataBitsPerMask(8), .OutputReg(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_write_i(a_write), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_wmask_i(a_wmask), .a_rdata_o(a_rdata0), .a_rvalid_o(a_rvalid0),
    .b_req_i(b_req), .b_write_i(b_write), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_wmask_i(b_wmask), .b_rdata_o(b_rdata0), .b_rvalid_o(b_rvalid0),
    .collision_o(col0)
  );

  prim_ram_2p_sync #(.Width(W), .Depth(DEPTH), .DataBitsPerMask(8), .OutputReg(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_write_i(a_write), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_wmask_i(a_wmask), .a_rdata_o(a_rdata1), .a_rvalid_o(a_rvalid1),
    .b_req_i(b_req), .b_write_i(b_write), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_wmask_i(b_wmask), .b_rdata_o(b_rdata1), .b_rvalid_o(b_rvalid1),
    .collision_o(col1)
  );

  // ------------------------------------------------------------------
  // Reference model: an array of words plus the results each instance
  // should be showing, derived from the read/write/collision rules.
  // ------------------------------------------------------------------
  logic [31:0] m_mem [128];
  bit          e0_av, e0_bv, e1_av, e1_bv, e_col;
  logic [31:0] e0_ad, e0_bd, e1_ad, e1_bd;
  // Result that dut1 will present one edge later.
  bit          p_av, p_bv;
  logic [31:0] p_ad, p_bd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_edge(input vec_t v);
    bit          a_rd, a_wr, b_rd, b_wr, a_in, b_in, col;
    logic [31:0] ra, rb;
    if (v.rst) begin
      {e0_av, e0_bv, e1_av, e1_bv, e_col, p_av, p_bv} = '0;
      {e0_ad, e0_bd, e1_ad, e1_bd, p_ad, p_bd} = '0;
      return;
    end
    a_rd = v.a_req && !v.a_write;
    a_wr = v.a_req &&  v.a_write;
    b_rd = v.b_req && !v.b_write;
    b_wr = v.b_req &&  v.b_write;
    a_in = int'(v.a_addr) < DEPTH;
    b_in = int'(v.b_addr) < DEPTH;
    ra   = a_in ? m_mem[v.a_addr] : 32'h0;
    rb   = b_in ? m_mem[v.b_addr] : 32'h0;
    col  = a_in && (v.a_addr == v.b_addr) &&
           ((a_wr && b_wr && (v.a_mask & v.b_mask) != 0) ||
            (a_wr && v.a_mask != 0 && b_rd) ||
            (b_wr && v.b_mask != 0 && a_rd));
    // Two-cycle instance shows last edge's result now.
    e1_av = p_av;
    e1_bv = p_bv;
    if (p_av) e1_ad = p_ad;
    if (p_bv) e1_bd = p_bd;
    p_av = a_rd; p_ad = ra;
    p_bv = b_rd; p_bd = rb;
    // One-cycle instance shows this edge's result.
    e0_av = a_rd;
    e0_bv = b_rd;
    if (a_rd) e0_ad = ra;
    if (b_rd) e0_bd = rb;
    e_col = col;
    // Apply B then A so that A owns any lane both ports enable.
    for (int l = 0; l < 4; l++) begin
      if (b_wr && b_in && v.b_mask[l]) m_mem[v.b_addr][l*8 +: 8] = v.b_wdata[l*8 +: 8];
      if (a_wr && a_in && v.a_mask[l]) m_mem[v.a_addr][l*8 +: 8] = v.a_wdata[l*8 +: 8];
    end
  endtask

  function automatic vec_t v(input bit r,
                             input bit ar, input bit aw, input int aa, input logic [31:0] ad,
                             input logic [3:0] am,
                             input bit br, input bit bw, input int ba, input logic [31:0] bd,
                             input logic [3:0] bm);
    vec_t x;
    x.rst = r;
    x.a_req = ar; x.a_write = aw; x.a_addr = 7'(aa); x.a_wdata = ad; x.a_mask = am;
    x.b_req = br; x.b_write = bw; x.b_addr = 7'(ba); x.b_wdata = bd; x.b_mask = bm;
    return x;
  endfunction

  function automatic row_t mk(input vec_t in, input bit xav, input logic [31:0] xad,
                              input bit xbv, input logic [31:0] xbd, input bit xcol);
    row_t r;
    r.in = in; r.xav = xav; r.xad = xad; r.xbv = xbv; r.xbd = xbd; r.xcol = xcol;
    return r;
  endfunction

  // Drive one cycle of inputs, let the edge happen, then compare both
  // instances against the model 1 ns after the edge.
  task automatic cycle(input vec_t x);
    rst     = x.rst;
    a_req   = x.a_req; a_write = x.a_write; a_addr = x.a_addr;
    a_wdata = x.a_wdata; a_wmask = x.a_mask;
    b_req   = x.b_req; b_write = x.b_write; b_addr = x.b_addr;
    b_wdata = x.b_wdata; b_wmask = x.b_mask;
    @(posedge clk);
    model_edge(x);
    #1;
    check("m0 a_rvalid", 32'(a_rvalid0), 32'(e0_av));
    check("m0 a_rdata",  a_rdata0, e0_ad);
    check("m0 b_rvalid", 32'(b_rvalid0), 32'(e0_bv));
    check("m0 b_rdata",  b_rdata0, e0_bd);
    check("m0 collision", 32'(col0), 32'(e_col));
    check("m1 a_rvalid", 32'(a_rvalid1), 32'(e1_av));
    check("m1 a_rdata",  a_rdata1, e1_ad);
    check("m1 b_rvalid", 32'(b_rvalid1), 32'(e1_bv));
    check("m1 b_rdata",  b_rdata1, e1_bd);
    check("m1 collision", 32'(col1), 32'(e_col));
  endtask

  vec_t idle;
  row_t tbl[$];

  initial begin
    idle = v(0, 0,0,0,0,0, 0,0,0,0,0);

    // Directed table: expected dut0 outputs right after each edge.
    tbl.push_back(mk(v(1, 0,0,0,0,0, 0,0,0,0,0),                      0,0, 0,0, 0));
    tbl.push_back(mk(v(1, 0,0,0,0,0, 0,0,0,0,0),                      0,0, 0,0, 0));
    tbl.push_back(mk(v(0, 1,1,6,32'h0A0A0A0A,4'hF, 0,0,0,0,0),        0,0, 0,0, 0));
    tbl.push_back(mk(v(1, 1,1,6,32'hFFFFFFFF,4'hF, 0,0,0,0,0),        0,0, 0,0, 0));
    tbl.push_back(mk(v(0, 1,1,5,32'hDEADBEEF,4'hF, 1,1,7,32'hFFFFFFFF,4'hF), 0,0, 0,0, 0));
    tbl.push_back(mk(v(0, 0,0,0,0,0, 1,0,5,0,0),                      0,0, 1,32'hDEADBEEF, 0));
    tbl.push_back(mk(v(0, 0,0,0,0,0, 1,0,6,0,0),                      0,0, 1,32'h0A0A0A0A, 0));
    tbl.push_back(mk(idle,                                             0,0, 0,32'h0A0A0A0A, 0));
    tbl.push_back(mk(v(0, 1,1,7,32'h000000FF,4'b0011, 1,1,7,32'hFFFF0000,4'b0110),
                                                                       0,0, 0,32'h0A0A0A0A, 1));
    tbl.push_back(mk(v(0, 1,0,7,0,0, 0,0,0,0,0),                      1,32'hFFFF00FF, 0,32'h0A0A0A0A, 0));
    tbl.push_back(mk(v(0, 1,1,7,32'h000000FF,4'b0011, 1,1,7,32'h11220000,4'b1100),
                                                                       0,32'hFFFF00FF, 0,32'h0A0A0A0A, 0));
    tbl.push_back(mk(v(0, 1,0,7,0,0, 0,0,0,0,0),                      1,32'h112200FF, 0,32'h0A0A0A0A, 0));
    tbl.push_back(mk(v(0, 1,1,9,32'h1,4'hF, 0,0,0,0,0),               0,32'h112200FF, 0,32'h0A0A0A0A, 0));
    tbl.push_back(mk(v(0, 1,1,9,32'h2,4'hF, 1,0,9,0,0),               0,32'h112200FF, 1,32'h1, 1));
    tbl.push_back(mk(v(0, 0,0,0,0,0, 1,0,9,0,0),                      0,32'h112200FF, 1,32'h2, 0));
    tbl.push_back(mk(idle,                                             0,32'h112200FF, 0,32'h2, 0));
    tbl.push_back(mk(v(0, 1,1,0,32'hCAFEF00D,4'hF, 1,1,99,32'h99999999,4'hF),
                                                                       0,32'h112200FF, 0,32'h2, 0));
    tbl.push_back(mk(v(0, 1,1,100,32'h55,4'hF, 0,0,0,0,0),            0,32'h112200FF, 0,32'h2, 0));
    tbl.push_back(mk(v(0, 1,0,100,0,0, 1,0,99,0,0),                   1,32'h0, 1,32'h99999999, 0));
    tbl.push_back(mk(v(0, 1,0,0,0,0, 0,0,0,0,0),                      1,32'hCAFEF00D, 0,32'h99999999, 0));
    tbl.push_back(mk(v(0, 1,1,0,32'hFFFFFFFF,4'h0, 0,0,0,0,0),        0,32'hCAFEF00D, 0,32'h99999999, 0));
    tbl.push_back(mk(v(0, 1,0,0,0,0, 0,0,0,0,0),                      1,32'hCAFEF00D, 0,32'h99999999, 0));

    foreach (tbl[i]) begin
      cycle(tbl[i].in);
      check($sformatf("row%0d a_rvalid", i), 32'(a_rvalid0), 32'(tbl[i].xav));
      check($sformatf("row%0d a_rdata", i),  a_rdata0, tbl[i].xad);
      check($sformatf("row%0d b_rvalid", i), 32'(b_rvalid0), 32'(tbl[i].xbv));
      check($sformatf("row%0d b_rdata", i),  b_rdata0, tbl[i].xbd);
      check($sformatf("row%0d collision", i), 32'(col0), 32'(tbl[i].xcol));
    end

    // Partial mask through the output register: three back-to-back reads,
    // each completing two cycles after its request.
    cycle(v(0, 1,1,3,32'h11223344,4'hF, 0,0,0,0,0));
    cycle(v(0, 1,1,3,32'hAABBCCDD,4'b0101, 0,0,0,0,0));
    for (int k = 0; k < 5; k++) begin
      cycle(k < 3 ? v(0, 1,0,3,0,0, 0,0,0,0,0) : idle);
      check($sformatf("oreg rvalid%0d", k), 32'(a_rvalid1), (k >= 1 && k <= 3) ? 32'h1 : 32'h0);
      if (k >= 1) check($sformatf("oreg rdata%0d", k), a_rdata1, 32'h11BB33DD);
    end

    // Reset one cycle after a read request drops that read on dut1, but
    // the array keeps its contents.
    cycle(v(0, 0,0,0,0,0, 1,1,1,32'h0BADCAFE,4'hF));
    cycle(v(0, 0,0,0,0,0, 1,0,1,0,0));
    check("rst_mid rvalid N",  32'(b_rvalid1), 32'h0);
    cycle(v(1, 0,0,0,0,0, 0,0,0,0,0));
    check("rst_mid rvalid N+1", 32'(b_rvalid1), 32'h0);
    cycle(idle);
    check("rst_mid rvalid N+2", 32'(b_rvalid1), 32'h0);
    check("rst_mid rdata cleared", b_rdata1, 32'h0);
    cycle(v(0, 0,0,0,0,0, 1,0,1,0,0));
    cycle(idle);
    check("rst_mid reread rvalid", 32'(b_rvalid1), 32'h1);
    check("rst_mid reread rdata",  b_rdata1, 32'h0BADCAFE);

    // Give every in-range word a known value, then run random traffic.
    for (int i = 0; i < DEPTH; i++)
      cycle(v(0, 1,1,i,$urandom,4'hF, 0,0,0,0,0));

    for (int n = 0; n < 600; n++) begin
      vec_t x;
      int   aa, ba;
      aa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 5));
      ba = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 5));
      x = v($urandom_range(0, 49) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, aa, $urandom, 4'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ba, $urandom, 4'($urandom));
      cycle(x);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
